// File: rtl/vga_timing_gen_if.sv
// vga_if: timing bundle driven by vga_timing_gen toward downstream draw stages.
interface vga_if;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned RGB_W = 12;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counter with registered sync/blank decode.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int unsigned HOR_PIXELS = 800,
    parameter int unsigned HOR_FP     = 40,
    parameter int unsigned HOR_SYNC   = 128,
    parameter int unsigned HOR_BP     = 88,
    parameter int unsigned VER_PIXELS = 600,
    parameter int unsigned VER_FP     = 1,
    parameter int unsigned VER_SYNC   = 4,
    parameter int unsigned VER_BP     = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    vga_if.out          vga_out,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned RGB_W = 12;

    localparam int unsigned HOR_TOTAL = HOR_PIXELS + HOR_FP + HOR_SYNC + HOR_BP;
    localparam int unsigned VER_TOTAL = VER_PIXELS + VER_FP + VER_SYNC + VER_BP;
    localparam int unsigned HS_START  = HOR_PIXELS + HOR_FP;
    localparam int unsigned HS_END    = HS_START + HOR_SYNC;
    localparam int unsigned VS_START  = VER_PIXELS + VER_FP;
    localparam int unsigned VS_END    = VS_START + VER_SYNC;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HOR_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(VER_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(HOR_PIXELS);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(VER_PIXELS);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(HS_END);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(VS_START);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(VS_END);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             frame_start_q, frame_start_d;
    logic             h_end, v_end;

    // Next-count and flag decode; flags come from the next counts so they line up with them.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        h_end         = (hcount_q == H_LAST);
        v_end         = (vcount_q == V_LAST);

        if (en) begin
            hcount_d = h_end ? '0 : hcount_q + CNT_W'(1);
            if (h_end) begin
                vcount_d = v_end ? '0 : vcount_q + CNT_W'(1);
            end
            frame_start_d = h_end && v_end;
        end

        hblnk_d = (hcount_d >= H_ACT_END);
        vblnk_d = (vcount_d >= V_ACT_END);
        hsync_d = (hcount_d >= H_SYNC_LO) && (hcount_d < H_SYNC_HI);
        vsync_d = (vcount_d >= V_SYNC_LO) && (vcount_d < V_SYNC_HI);
    end

    // Timing registers; reset parks the raster at (0,0) with all flags low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    // Colour is owned by downstream draw stages; the timing block emits black.
    assign vga_out.rgb    = RGB_W'(0);
    assign frame_start    = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter advances on the same edge that raises frame_start; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a full-size instance (line timing, freeze)
// and a shrunken instance (frame wrap, mid-frame reset, optional frame counter).
module tb_vga_timing_gen;

    // Shrunken geometry: 16 clocks per line, 12 lines per frame.
    localparam int unsigned S_HP = 8;
    localparam int unsigned S_HF = 2;
    localparam int unsigned S_HS = 3;
    localparam int unsigned S_HB = 3;
    localparam int unsigned S_VP = 6;
    localparam int unsigned S_VF = 1;
    localparam int unsigned S_VS = 2;
    localparam int unsigned S_VB = 3;
    localparam int unsigned S_HT = S_HP + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT = S_VP + S_VF + S_VS + S_VB;
    localparam int unsigned S_FT = S_HT * S_VT;

    typedef struct {
        int   n;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic hb;
        logic vb;
        logic fs;
    } vec_t;

    logic clk;
    logic rst_n;
    logic en_f;
    logic en_s;
    logic fs_f;
    logic fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_f;
    logic [15:0] fc_s;
`endif

    vga_if vif_f ();
    vga_if vif_s ();

    int errors = 0;
    int checks = 0;
    int sn     = 0;
    int fs_seen;

    vga_timing_gen dut_f (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_f),
        .vga_out     (vif_f),
        .frame_start (fs_f)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_f)
`endif
    );

    vga_timing_gen #(
        .HOR_PIXELS (S_HP), .HOR_FP (S_HF), .HOR_SYNC (S_HS), .HOR_BP (S_HB),
        .VER_PIXELS (S_VP), .VER_FP (S_VF), .VER_SYNC (S_VS), .VER_BP (S_VB)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_s),
        .vga_out     (vif_s),
        .frame_start (fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_full(input string tag, input int h, input int v, input logic hs,
                              input logic vs, input logic hb, input logic vb, input logic fs);
        check({tag, ".hcount"}, 32'(vif_f.hcount), 32'(h));
        check({tag, ".vcount"}, 32'(vif_f.vcount), 32'(v));
        check({tag, ".hsync"},  32'(vif_f.hsync),  32'(hs));
        check({tag, ".vsync"},  32'(vif_f.vsync),  32'(vs));
        check({tag, ".hblnk"},  32'(vif_f.hblnk),  32'(hb));
        check({tag, ".vblnk"},  32'(vif_f.vblnk),  32'(vb));
        check({tag, ".frame_start"}, 32'(fs_f), 32'(fs));
    endtask

    // Expected small-instance outputs after n enabled edges since reset release.
    task automatic check_small(input string tag, input int n);
        int h;
        int v;
        h = n % S_HT;
        v = (n / S_HT) % S_VT;
        check({tag, ".hcount"}, 32'(vif_s.hcount), 32'(h));
        check({tag, ".vcount"}, 32'(vif_s.vcount), 32'(v));
        check({tag, ".hsync"},  32'(vif_s.hsync),  32'(h >= 10 && h <= 12));
        check({tag, ".vsync"},  32'(vif_s.vsync),  32'(v >= 7 && v <= 8));
        check({tag, ".hblnk"},  32'(vif_s.hblnk),  32'(h >= 8));
        check({tag, ".vblnk"},  32'(vif_s.vblnk),  32'(v >= 6));
        check({tag, ".frame_start"}, 32'(fs_s), 32'(n > 0 && (n % 192) == 0));
    endtask

    task automatic run_small(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            sn++;
            fs_seen += int'(fs_s);
            check_small(tag, sn);
        end
    endtask

    initial begin
        vec_t tbl[11];
        int   prev_v;
        int   hs_cnt;
        int   hb_cnt;

        //               n     h    v  hs vs hb vb fs
        tbl[0]  = '{    1,    1,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{  799,  799,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{  800,  800,   0, 0, 0, 1, 0, 0};
        tbl[3]  = '{  839,  839,   0, 0, 0, 1, 0, 0};
        tbl[4]  = '{  840,  840,   0, 1, 0, 1, 0, 0};
        tbl[5]  = '{  967,  967,   0, 1, 0, 1, 0, 0};
        tbl[6]  = '{  968,  968,   0, 0, 0, 1, 0, 0};
        tbl[7]  = '{ 1055, 1055,   0, 0, 0, 1, 0, 0};
        tbl[8]  = '{ 1056,    0,   1, 0, 0, 0, 0, 0};
        tbl[9]  = '{ 1057,    1,   1, 0, 0, 0, 0, 0};
        tbl[10] = '{ 1556,  500,   1, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        en_f  = 1'b0;
        en_s  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_full("reset_f", 0, 0, 0, 0, 0, 0, 0);
        check("reset_f.rgb", 32'(vif_f.rgb), 32'(0));
        check_small("reset_s", 0);

        // Full-size line: table points plus per-line width counts.
        @(negedge clk);
        rst_n  = 1'b1;
        en_f   = 1'b1;
        prev_v = 0;
        hs_cnt = 0;
        hb_cnt = 0;
        for (int n = 1; n <= 1556; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 11; k++) begin
                if (tbl[k].n == n) begin
                    check_full($sformatf("line_n%0d", n), tbl[k].h, tbl[k].v, tbl[k].hs,
                               tbl[k].vs, tbl[k].hb, tbl[k].vb, tbl[k].fs);
                end
            end
            if (n <= 1056) begin
                hs_cnt += int'(vif_f.hsync);
                hb_cnt += int'(vif_f.hblnk);
            end
            if (int'(vif_f.vcount) != prev_v) begin
                check("vstep_at_hwrap", 32'(vif_f.hcount), 32'(0));
            end
            prev_v = int'(vif_f.vcount);
        end
        check("hsync_width", 32'(hs_cnt), 32'(128));
        check("hblnk_width", 32'(hb_cnt), 32'(256));
        check("rgb_const", 32'(vif_f.rgb), 32'(0));

        // Enable low for 10 edges at hcount=500, then resume.
        @(negedge clk);
        en_f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_full("freeze", 500, 1, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        en_f = 1'b1;
        @(posedge clk);
        #1;
        check_full("resume", 501, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        en_f = 1'b0;

        // Small instance: two full frames plus a bit, frame_start exactly at each wrap.
        en_s    = 1'b1;
        sn      = 0;
        fs_seen = 0;
        run_small("frame", 400);
        check("frame_start_count", 32'(fs_seen), 32'(2));

        // Advance to (13,4) of the third frame, then reset between clock edges.
        run_small("pre_rst", 61);
        check("pre_rst.pos", 32'({vif_s.vcount, vif_s.hcount}), 32'({11'd4, 11'd13}));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_full("async_rst_f", 0, 0, 0, 0, 0, 0, 0);
        check_small("async_rst_s", 0);
        @(posedge clk);
        #1;
        check_small("held_rst_s", 0);
        @(negedge clk);
        rst_n   = 1'b1;
        sn      = 0;
        fs_seen = 0;
        run_small("restart", 200);
        check("restart_fs_count", 32'(fs_seen), 32'(1));
        check_full("idle_f", 0, 0, 0, 0, 0, 0, 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("fcnt_reset", 32'(fc_s), 32'(0));
        rst_n   = 1'b1;
        sn      = 0;
        fs_seen = 0;
        run_small("fcnt", 3 * S_FT);
        check("fcnt_three", 32'(fc_s), 32'(3));
        @(negedge clk);
        en_s = 1'b0;
        force dut_s.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_s.frame_cnt_q;
        check("fcnt_forced", 32'(fc_s), 32'(16'hFFFF));
        en_s = 1'b1;
        run_small("fcnt_wrap", S_FT);
        check("fcnt_wrap", 32'(fc_s), 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
